// File: rtl/bof_range_store.sv
// rtl/bof_range_store.sv - circular store of heap-overflow address ranges with combinational lookup
module bof_range_store #(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_write_i,
   input  logic             is_big_i,
   input  logic [AW-1:0]    addr_first_i,
   input  logic [AW-1:0]    addr_last_i,
   input  logic [AW-1:0]    find_addr_i,
   output logic             addr_in_range_o,
   output logic             addr_is_first_o,
   output logic             hit_big_o,
   output logic [AW-1:0]    read_o,
   output logic [AW-1:0]    read2_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o
);

   localparam int               PW      = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   // Entry state: valid/big are reset; bounds are only meaningful under valid.
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] big_q, big_d;
   logic [AW-1:0]    first_q [DEPTH];
   logic [AW-1:0]    last_q  [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             range_ok;
   logic             dup_hit;
   logic             do_write;
   logic [DEPTH-1:0] dup_vec;
   logic [DEPTH-1:0] hit_vec;
   logic [DEPTH-1:0] first_vec;
   logic             sel_found;
   logic [PW-1:0]    sel_idx;

   // Exact {first,last} match of the incoming range against each valid entry.
   always_comb begin
      dup_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         dup_vec[i] = valid_q[i] && (first_q[i] == addr_first_i) && (last_q[i] == addr_last_i);
      end
   end

   assign range_ok = (addr_first_i <= addr_last_i);
   assign dup_hit  = |dup_vec;
   // A new entry is allocated only for a well-formed range not already held.
   assign do_write = en_write_i && !clr_i && range_ok && !dup_hit;

   // Next-state for control bits: clear beats write, duplicates only merge the big tag.
   always_comb begin
      valid_d  = valid_q;
      big_d    = big_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         valid_d  = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (en_write_i && range_ok) begin
         if (dup_hit) begin
            big_d = big_q | (dup_vec & {DEPTH{is_big_i}});
         end else begin
            valid_d[wr_ptr_q] = 1'b1;
            big_d[wr_ptr_q]   = is_big_i;
            wr_ptr_d          = wr_ptr_q + PW'(1);
            if (count_q != CNT_MAX) begin
               count_d = count_q + CNT_W'(1);
            end
         end
      end
   end

   // Control registers with asynchronous reset; a write racing reset is lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= '0;
         big_q    <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         big_q    <= big_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Bound storage; left unreset because it is never observed without valid.
   always_ff @(posedge clk_i) begin
      if (do_write) begin
         first_q[wr_ptr_q] <= addr_first_i;
         last_q[wr_ptr_q]  <= addr_last_i;
      end
   end

   // Per-entry inclusive range hit and start-address hit for the lookup address.
   always_comb begin
      hit_vec   = '0;
      first_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i]   = valid_q[i] && (find_addr_i >= first_q[i]) && (find_addr_i <= last_q[i]);
         first_vec[i] = valid_q[i] && (find_addr_i == first_q[i]);
      end
   end

   // Newest-first search: wr_ptr-1 down to wr_ptr (k = DEPTH wraps to wr_ptr itself).
   always_comb begin
      logic [PW-1:0] idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         idx = wr_ptr_q - PW'(k);
         if (!sel_found && hit_vec[idx]) begin
            sel_found = 1'b1;
            sel_idx   = idx;
         end
      end
   end

   assign addr_in_range_o = sel_found;
   assign addr_is_first_o = |first_vec;
   assign hit_big_o       = sel_found && big_q[sel_idx];
   assign read_o          = sel_found ? first_q[sel_idx] : '0;
   assign read2_o         = sel_found ? last_q[sel_idx]  : '0;
   assign count_o         = count_q;
   assign full_o          = (count_q == CNT_MAX);

endmodule

// File: tb/tb_bof_range_store.sv
// tb/tb_bof_range_store.sv - randomized model-checked bench for bof_range_store
module tb_bof_range_store;

   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             clr_i;
   logic             en_write_i;
   logic             is_big_i;
   logic [AW-1:0]    addr_first_i;
   logic [AW-1:0]    addr_last_i;
   logic [AW-1:0]    find_addr_i;
   logic             addr_in_range_o;
   logic             addr_is_first_o;
   logic             hit_big_o;
   logic [AW-1:0]    read_o;
   logic [AW-1:0]    read2_o;
   logic [CNT_W-1:0] count_o;
   logic             full_o;

   always #5 clk_i = ~clk_i;

   bof_range_store #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .en_write_i(en_write_i),
      .is_big_i(is_big_i), .addr_first_i(addr_first_i), .addr_last_i(addr_last_i),
      .find_addr_i(find_addr_i), .addr_in_range_o(addr_in_range_o),
      .addr_is_first_o(addr_is_first_o), .hit_big_o(hit_big_o), .read_o(read_o),
      .read2_o(read2_o), .count_o(count_o), .full_o(full_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model: ranges in write order, oldest at index 0.
   typedef struct {
      logic [AW-1:0] f;
      logic [AW-1:0] l;
      bit            big;
   } rng_t;
   rng_t m_q[$];

   bit            e_inr, e_isf, e_big;
   logic [AW-1:0] e_r1, e_r2;

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_look(input logic [AW-1:0] a, output bit inr, output bit isf,
                                      output bit big, output logic [AW-1:0] r1, output logic [AW-1:0] r2);
      inr = 0; isf = 0; big = 0; r1 = '0; r2 = '0;
      for (int i = m_q.size() - 1; i >= 0; i--) begin
         if (m_q[i].f == a) isf = 1;
         if (!inr && a >= m_q[i].f && a <= m_q[i].l) begin
            inr = 1; big = m_q[i].big; r1 = m_q[i].f; r2 = m_q[i].l;
         end
      end
   endfunction

   task automatic model_apply();
      bit dup;
      dup = 0;
      if (!rst_ni || clr_i) begin
         m_q.delete();
      end else if (en_write_i && addr_first_i <= addr_last_i) begin
         foreach (m_q[i]) begin
            if (m_q[i].f == addr_first_i && m_q[i].l == addr_last_i) begin
               m_q[i].big = m_q[i].big | is_big_i;
               dup = 1;
            end
         end
         if (!dup) begin
            m_q.push_back('{f: addr_first_i, l: addr_last_i, big: is_big_i});
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
         end
      end
   endtask

   // Compare every output against the model once per cycle, mid-period.
   always @(negedge clk_i) begin
      if (chk_en) begin
         model_look(find_addr_i, e_inr, e_isf, e_big, e_r1, e_r2);
         chk("cyc_in_range", addr_in_range_o, e_inr);
         chk("cyc_is_first", addr_is_first_o, e_isf);
         chk("cyc_hit_big", hit_big_o, e_big);
         chk("cyc_read", read_o, e_r1);
         chk("cyc_read2", read2_o, e_r2);
         chk("cyc_count", count_o, m_q.size());
         chk("cyc_full", full_o, m_q.size() == DEPTH);
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      model_apply();
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] f, input logic [AW-1:0] l, input bit b);
      en_write_i = 1; addr_first_i = f; addr_last_i = l; is_big_i = b;
      cyc();
      en_write_i = 0; is_big_i = 0;
   endtask

   task automatic clr();
      clr_i = 1;
      cyc();
      clr_i = 0;
   endtask

   task automatic look(input logic [AW-1:0] a);
      find_addr_i = a;
      #1;
   endtask

   task automatic rand_cycles(input int n);
      logic [AW-1:0] f;
      for (int c = 0; c < n; c++) begin
         en_write_i = ($urandom_range(0, 3) != 0);
         clr_i      = ($urandom_range(0, 59) == 0);
         is_big_i   = $urandom_range(0, 1);
         f          = AW'($urandom_range(0, 15)) << 6;
         addr_first_i = f;
         if ($urandom_range(0, 7) == 0 && f != 0)
            addr_last_i = f - 1;
         else
            addr_last_i = f + AW'($urandom_range(0, 3)) * 32'h20 + AW'($urandom_range(0, 1)) * 32'h1F;
         if ($urandom_range(0, 2) == 0)
            find_addr_i = AW'($urandom_range(0, 15)) << 6;
         else
            find_addr_i = AW'($urandom_range(0, 32'h480));
         cyc();
      end
      en_write_i = 0; clr_i = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 0; clr_i = 0; en_write_i = 0; is_big_i = 0;
      addr_first_i = '0; addr_last_i = '0; find_addr_i = 32'h1000;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_in_range", addr_in_range_o, 0);
      chk("rst_is_first", addr_is_first_o, 0);
      chk("rst_read", read_o, 0);
      chk("rst_read2", read2_o, 0);
      chk("rst_count", count_o, 0);
      rst_ni = 1;
      chk_en = 1;
      cyc();

      wr(32'h1000, 32'h1013, 0);
      look(32'h1000);
      chk("w1_in_range", addr_in_range_o, 1);
      chk("w1_is_first", addr_is_first_o, 1);
      chk("w1_read", read_o, 32'h1000);
      chk("w1_read2", read2_o, 32'h1013);
      look(32'h1013);
      chk("w1_last_in", addr_in_range_o, 1);
      chk("w1_last_first", addr_is_first_o, 0);
      look(32'h1014);
      chk("w1_past_end", addr_in_range_o, 0);

      clr();
      for (int k = 1; k <= 9; k++) wr(32'h100 * k, 32'h100 * k + 32'h1F, 0);
      chk("wrap_count", count_o, 8);
      chk("wrap_full", full_o, 1);
      look(32'h100);
      chk("wrap_evicted", addr_in_range_o, 0);
      look(32'h900);
      chk("wrap_newest", read_o, 32'h900);

      clr();
      wr(32'h2000, 32'h20FF, 0);
      wr(32'h2080, 32'h217F, 1);
      look(32'h20A0);
      chk("ovl_read", read_o, 32'h2080);
      chk("ovl_big", hit_big_o, 1);

      clr();
      wr(32'h3000, 32'h300F, 0);
      wr(32'h3000, 32'h300F, 1);
      look(32'h3000);
      chk("dup_count", count_o, 1);
      chk("dup_big", hit_big_o, 1);
      wr(32'h40, 32'h3F, 0);
      chk("bad_range_count", count_o, 1);

      en_write_i = 1; clr_i = 1; addr_first_i = 32'h5000; addr_last_i = 32'h500F;
      cyc();
      en_write_i = 0; clr_i = 0;
      chk("clrw_count", count_o, 0);
      look(32'h5000);
      chk("clrw_new_miss", addr_in_range_o, 0);
      look(32'h3000);
      chk("clrw_old_miss", addr_in_range_o, 0);

      rand_cycles(400);

      for (int k = 0; k < 5; k++) wr(32'h600 + 32'h40 * k, 32'h61F + 32'h40 * k, 1);
      en_write_i = 1; addr_first_i = 32'h800; addr_last_i = 32'h80F; is_big_i = 1;
      find_addr_i = 32'h600;
      #2;
      rst_ni = 0;
      m_q.delete();
      #1;
      chk("arst_in_range", addr_in_range_o, 0);
      chk("arst_is_first", addr_is_first_o, 0);
      chk("arst_big", hit_big_o, 0);
      chk("arst_read", read_o, 0);
      chk("arst_read2", read2_o, 0);
      chk("arst_count", count_o, 0);
      chk("arst_full", full_o, 0);
      cyc();
      rst_ni = 1;
      en_write_i = 0; is_big_i = 0;
      look(32'h800);
      chk("arst_write_lost", addr_in_range_o, 0);

      rand_cycles(300);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
